// File: rtl/conc_stim_sequencer.sv
// Stimulus player: replays a loadable program of {repeat, payload} words onto DUT inputs,
// with one-shot, loop and single-step playback, start/stop control and status outputs.
module conc_stim_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned REP_W  = 4,
  parameter int unsigned LOOP_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [REP_W+DATA_W-1:0] wr_data,
  output logic                    wr_err,
  input  logic [1:0]              mode,
  input  logic [ADDR_W-1:0]       last_addr,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    step,
  output logic [DATA_W-1:0]       stim_out,
  output logic                    stim_valid,
  output logic [ADDR_W-1:0]       pc,
  output logic                    busy,
  output logic                    done,
  output logic [LOOP_W-1:0]       loop_cnt
);

  localparam int unsigned WordW = REP_W + DATA_W;
  localparam logic [ADDR_W-1:0] MaxAddr = ADDR_W'(DEPTH - 1);
  localparam logic [1:0] ModeLoop = 2'b01;
  localparam logic [1:0] ModeStep = 2'b10;

  typedef enum logic [1:0] {StIdle, StRun, StStepWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [REP_W-1:0]    rep_q, rep_d;
  logic [DATA_W-1:0]   stim_q, stim_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [LOOP_W-1:0]   loop_q, loop_d;
  logic                wr_err_q, wr_err_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   last_q, last_d;

  logic [WordW-1:0]    mem_q [DEPTH];

  logic                wr_ok;
  logic [WordW-1:0]    word0;
  logic [WordW-1:0]    cur_word;
  logic [WordW-1:0]    nxt_word;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [ADDR_W-1:0]   last_clamp;
  logic                at_last;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      rep_q    <= '0;
      stim_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      loop_q   <= '0;
      wr_err_q <= 1'b0;
      mode_q   <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rep_q    <= rep_d;
      stim_q   <= stim_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      loop_q   <= loop_d;
      wr_err_q <= wr_err_d;
      mode_q   <= mode_d;
      last_q   <= last_d;
    end
  end

  // Program memory survives reset.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rep_d    = rep_q;
    stim_d   = stim_q;
    valid_d  = 1'b0;
    done_d   = done_q;
    loop_d   = loop_q;
    mode_d   = mode_q;
    last_d   = last_q;

    wr_ok    = wr_en && !busy && (32'(wr_addr) < DEPTH);
    wr_err_d = wr_en && !wr_ok;
    last_clamp = (32'(last_addr) >= DEPTH) ? MaxAddr : last_addr;

    // A write accepted alongside start must be visible to the first fetched word.
    word0    = (wr_ok && (wr_addr == '0)) ? wr_data : mem_q[0];
    cur_word = mem_q[pc_q];
    at_last  = (pc_q == last_q);
    nxt_addr = at_last ? '0 : pc_q + 1'b1;
    nxt_word = mem_q[nxt_addr];

    if (stop && busy) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start && !stop) begin
            mode_d = mode;
            last_d = last_clamp;
            pc_d   = '0;
            rep_d  = word0[WordW-1:DATA_W];
            done_d = 1'b0;
            loop_d = '0;
            if (mode == ModeStep) begin
              state_d = StStepWait;
            end else begin
              state_d = StRun;
              stim_d  = word0[DATA_W-1:0];
              valid_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (rep_q != '0) begin
            rep_d   = rep_q - 1'b1;
            valid_d = 1'b1;
          end else if (at_last && (mode_q != ModeLoop)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            pc_d    = nxt_addr;
            rep_d   = nxt_word[WordW-1:DATA_W];
            stim_d  = nxt_word[DATA_W-1:0];
            valid_d = 1'b1;
            if (at_last && (loop_q != '1)) begin
              loop_d = loop_q + 1'b1;
            end
          end
        end
        StStepWait: begin
          // The cycle after a presented word retires one repeat; a step landing then is dropped.
          if (valid_q) begin
            if (rep_q != '0) begin
              rep_d = rep_q - 1'b1;
            end else if (at_last) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              pc_d  = nxt_addr;
              rep_d = nxt_word[WordW-1:DATA_W];
            end
          end else if (step) begin
            stim_d  = cur_word[DATA_W-1:0];
            valid_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    busy       = (state_q == StRun) || (state_q == StStepWait);
    stim_out   = stim_q;
    stim_valid = valid_q;
    pc         = pc_q;
    done       = done_q;
    loop_cnt   = loop_q;
    wr_err     = wr_err_q;
  end

endmodule

// File: tb/tb_conc_stim_sequencer.sv
// Scoreboard bench for conc_stim_sequencer: directed programs push expected {pc, payload}
// words; a negedge monitor pops and compares on every stim_valid cycle.
module tb_conc_stim_sequencer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 12;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned REP_W  = 4;
  localparam int unsigned LOOP_W = 8;
  localparam int unsigned WordW  = REP_W + DATA_W;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                wr_en = 1'b0;
  logic [ADDR_W-1:0]   wr_addr = '0;
  logic [WordW-1:0]    wr_data = '0;
  logic                wr_err;
  logic [1:0]          mode = '0;
  logic [ADDR_W-1:0]   last_addr = '0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                step = 1'b0;
  logic [DATA_W-1:0]   stim_out;
  logic                stim_valid;
  logic [ADDR_W-1:0]   pc;
  logic                busy;
  logic                done;
  logic [LOOP_W-1:0]   loop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_word;

  conc_stim_sequencer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .REP_W (REP_W),
    .LOOP_W(LOOP_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .mode      (mode),
    .last_addr (last_addr),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .stim_out  (stim_out),
    .stim_valid(stim_valid),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .loop_cnt  (loop_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && stim_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: pc %0d stim %0h, nothing expected", pc, stim_out);
      end else begin
        exp_word = exp_q.pop_front();
        check("stim_word", {pc, stim_out}, exp_word);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [WordW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic push(input int p, input logic [DATA_W-1:0] d);
    exp_q.push_back({ADDR_W'(p), d});
  endtask

  // Leaves the bench in the first cycle after start was sampled.
  task automatic run_start(input logic [1:0] m, input int l);
    mode      = m;
    last_addr = ADDR_W'(l);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("rst_stim_out", stim_out, 0);
    check("rst_valid", stim_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_loop_cnt", loop_cnt, 0);
    check("rst_wr_err", wr_err, 0);
    reset = 1'b0;
    tick();

    // Out-of-range write is rejected with a one-cycle pulse.
    wr(12, {4'h0, 8'hFF});
    check("wr_err_range", wr_err, 1);
    tick();
    check("wr_err_pulse", wr_err, 0);

    for (int i = 0; i < 12; i++) begin
      wr(i, {4'h0, 8'h40 + 8'(i)});
    end
    check("wr_err_ok", wr_err, 0);

    // last_addr beyond the program clamps to word 11; mode 11 behaves as one-shot.
    for (int i = 0; i < 12; i++) push(i, 8'h40 + 8'(i));
    run_start(2'b11, 15);
    repeat (12) tick();
    check("clamp_done", done, 1);
    check("clamp_busy", busy, 0);
    check("clamp_pc", pc, 11);
    check("clamp_hold", stim_out, 8'h4B);
    check("clamp_q_empty", exp_q.size(), 0);

    // T1: two-word one-shot.
    wr(0, {4'h0, 8'hA5});
    wr(1, {4'h0, 8'h3C});
    push(0, 8'hA5);
    push(1, 8'h3C);
    run_start(2'b00, 1);
    check("t1_busy", busy, 1);
    check("t1_done_cleared", done, 0);
    tick();
    tick();
    check("t1_done", done, 1);
    check("t1_valid_low", stim_valid, 0);
    check("t1_hold", stim_out, 8'h3C);
    check("t1_busy_low", busy, 0);
    check("t1_q_empty", exp_q.size(), 0);

    // T2: repeat count 2 holds a single word three cycles.
    wr(0, {4'h2, 8'h11});
    repeat (3) push(0, 8'h11);
    run_start(2'b00, 0);
    tick();
    tick();
    check("t2_not_done", done, 0);
    tick();
    check("t2_done", done, 1);
    check("t2_q_empty", exp_q.size(), 0);

    // T3: loop mode over words 0..2.
    wr(0, {4'h0, 8'h40});
    wr(1, {4'h0, 8'h41});
    for (int k = 0; k < 10; k++) push(k % 3, 8'h40 + 8'(k % 3));
    run_start(2'b01, 2);
    check("t3_loop0", loop_cnt, 0);
    repeat (3) tick();
    check("t3_loop1", loop_cnt, 1);
    repeat (5) tick();
    check("t3_loop2", loop_cnt, 2);
    tick();
    check("t3_loop3", loop_cnt, 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t3_stop_busy", busy, 0);
    check("t3_stop_valid", stim_valid, 0);
    check("t3_stop_done", done, 0);
    check("t3_loop_held", loop_cnt, 3);
    check("t3_q_empty", exp_q.size(), 0);

    // T4: single-step, three pulses spaced four cycles.
    run_start(2'b10, 2);
    check("t4_busy", busy, 1);
    check("t4_idle_valid", stim_valid, 0);
    for (int k = 0; k < 3; k++) begin
      push(k, 8'h40 + 8'(k));
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (3) tick();
    end
    check("t4_done", done, 1);
    check("t4_busy_low", busy, 0);
    check("t4_pc", pc, 2);
    check("t4_q_empty", exp_q.size(), 0);

    // T5: write while busy is rejected; stop at pc=1 holds word 1.
    wr(1, {4'h3, 8'h41});
    push(0, 8'h40);
    push(1, 8'h41);
    run_start(2'b00, 2);
    wr_en   = 1'b1;
    wr_addr = 4'd2;
    wr_data = {4'h0, 8'hEE};
    tick();
    wr_en   = 1'b0;
    check("t5_wr_err_busy", wr_err, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_valid", stim_valid, 0);
    check("t5_hold", stim_out, 8'h41);
    check("t5_pc", pc, 1);
    check("t5_done", done, 0);
    check("t5_q_empty", exp_q.size(), 0);

    // T6: asynchronous reset mid-run, then replay from intact memory.
    wr(0, {4'h0, 8'hA5});
    wr(1, {4'h0, 8'h3C});
    run_start(2'b00, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_stim_out", stim_out, 0);
    check("t6_valid", stim_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_pc", pc, 0);
    check("t6_done", done, 0);
    tick();
    reset = 1'b0;
    push(0, 8'hA5);
    push(1, 8'h3C);
    push(2, 8'h42);
    run_start(2'b00, 2);
    repeat (3) tick();
    check("t6_done_after", done, 1);
    check("t6_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
